// File: rtl/add_accumulator_if.sv
// ---------------------------------------------------------------------------
// add_accumulator_if
//   Bundles the operand stream (input side) and the packet-result stream
//   (output side) of the add_accumulator into one interface.
//
//   Signals
//     in_valid   operand beat valid               (producer -> accumulator)
//     in_ready   accumulator can take a beat       (accumulator -> producer)
//     in_data    operand, NUMBITS wide             (producer -> accumulator)
//     in_last    beat closes the current packet    (producer -> accumulator)
//     out_valid  packet result valid               (accumulator -> consumer)
//     out_ready  consumer takes the result         (consumer -> accumulator)
//     out_sum    packet sum modulo 2^NUMBITS       (accumulator -> consumer)
//     out_carry  sticky unsigned carry-out         (accumulator -> consumer)
//     out_ovf    sticky signed overflow            (accumulator -> consumer)
//     out_count  saturating beat count             (accumulator -> consumer)
//
//   Modports
//     slave   : the accumulator's view
//     master  : the view of whoever feeds operands and drains results
// ---------------------------------------------------------------------------
interface add_accumulator_if #(
    parameter int NUMBITS = 16,
    parameter int CNTBITS = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] out_sum;
    logic               out_carry;
    logic               out_ovf;
    logic [CNTBITS-1:0] out_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_count
    );
endinterface

// File: rtl/add_accumulator.sv
// ---------------------------------------------------------------------------
// add_accumulator
//   Streaming accumulator built around a NUMBITS-bit ripple-carry adder.
//   Operand beats arrive over a valid/ready handshake and are summed until
//   the beat flagged in_last; the packet total, sticky carry / signed
//   overflow flags and a saturating beat count are then presented on a
//   registered valid/ready result port until the consumer takes them.
//
//   Ports
//     clk    in   single clock, all state updates on the rising edge
//     rst_n  in   asynchronous, active-low reset; discards any packet
//     bus    slave modport of add_accumulator_if (operand + result streams)
// ---------------------------------------------------------------------------
module add_accumulator #(
    parameter int NUMBITS = 16,
    parameter int CNTBITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    add_accumulator_if.slave  bus
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    logic               outValid_q;
    logic [NUMBITS-1:0] acc_q;
    logic               carry_q;
    logic               ovf_q;
    logic [CNTBITS-1:0] count_q;

    logic [NUMBITS-1:0] addSum;
    logic               addCarry;
    logic               carry_d;
    logic               ovf_d;
    logic [CNTBITS-1:0] count_d;

    // Ripple-carry adder: the accumulator plus the incoming operand, with a
    // zero carry-in. The carry is threaded bit by bit through a block-local
    // variable so the chain stays a plain combinational cascade.
    always_comb begin : rippleAdd
        logic carryChain;
        addSum     = '0;
        carryChain = 1'b0;
        for (int i = 0; i < NUMBITS; i++) begin
            addSum[i]  = acc_q[i] ^ bus.in_data[i] ^ carryChain;
            carryChain = (acc_q[i] & bus.in_data[i]) |
                         (carryChain & (acc_q[i] ^ bus.in_data[i]));
        end
        addCarry = carryChain;
    end

    // Values the flags and counter take if the current beat is accepted.
    // Signed overflow means both addends shared a sign and the sum did not;
    // the counter sticks at all-ones rather than wrapping.
    always_comb begin
        carry_d = carry_q | addCarry;
        ovf_d   = ovf_q |
                  ((acc_q[NUMBITS-1] == bus.in_data[NUMBITS-1]) &&
                   (addSum[NUMBITS-1] != acc_q[NUMBITS-1]));
        count_d = (count_q == {CNTBITS{1'b1}}) ? count_q
                                                : count_q + CNTBITS'(1);
    end

    // Packet FSM and datapath registers. ACCUM folds every valid beat into
    // the running total and moves to HOLD on the last one; HOLD freezes the
    // result until the consumer accepts it, then clears everything so the
    // next packet starts from zero one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            outValid_q <= 1'b0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q   <= addSum;
                        carry_q <= carry_d;
                        ovf_q   <= ovf_d;
                        count_q <= count_d;
                        if (bus.in_last) begin
                            state_q    <= HOLD;
                            outValid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q    <= ACCUM;
                        outValid_q <= 1'b0;
                        acc_q      <= '0;
                        carry_q    <= 1'b0;
                        ovf_q      <= 1'b0;
                        count_q    <= '0;
                    end
                end
                default: begin
                    state_q    <= ACCUM;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    // Every output is taken straight from a register; in_ready is a decode
    // of the state register, so no input feeds an output combinationally.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = outValid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_carry = carry_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_add_accumulator.sv
// ---------------------------------------------------------------------------
// tb_add_accumulator
//   Directed self-checking bench for add_accumulator (NUMBITS=16,
//   CNTBITS=8). Inputs are driven on the falling clock edge and outputs are
//   sampled on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_add_accumulator;

    localparam int NUMBITS = 16;
    localparam int CNTBITS = 8;

    logic clk;
    logic rst_n;

    int testsRun;
    int testsFailed;

    add_accumulator_if #(.NUMBITS(NUMBITS), .CNTBITS(CNTBITS)) bus ();

    add_accumulator #(.NUMBITS(NUMBITS), .CNTBITS(CNTBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents one operand beat at a falling edge and returns at the next
    // falling edge, by which time the rising edge in between has taken it.
    // Back-to-back calls keep in_valid high with no idle gap.
    task automatic applyStimulus(input logic [NUMBITS-1:0] data, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    // Checks a held packet result at the current falling edge.
    task automatic checkResult(input string tag, input logic [NUMBITS-1:0] sum,
                               input logic carry, input logic ovf,
                               input logic [CNTBITS-1:0] count);
        checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, ".ready"}, 32'(bus.in_ready),  32'd0);
        checkOutput({tag, ".sum"},   32'(bus.out_sum),   32'(sum));
        checkOutput({tag, ".carry"}, 32'(bus.out_carry), 32'(carry));
        checkOutput({tag, ".ovf"},   32'(bus.out_ovf),   32'(ovf));
        checkOutput({tag, ".count"}, 32'(bus.out_count), 32'(count));
    endtask

    // Accepts the held result and checks the block is back in ACCUM, cleared.
    task automatic drainResult(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, ".drainValid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, ".drainReady"}, 32'(bus.in_ready),  32'd1);
        checkOutput({tag, ".drainSum"},   32'(bus.out_sum),   32'd0);
        checkOutput({tag, ".drainCount"}, 32'(bus.out_count), 32'd0);
    endtask

    // Checks that every output shows the reset values.
    task automatic checkIdle(input string tag);
        checkOutput({tag, ".ready"}, 32'(bus.in_ready),  32'd1);
        checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, ".sum"},   32'(bus.out_sum),   32'd0);
        checkOutput({tag, ".carry"}, 32'(bus.out_carry), 32'd0);
        checkOutput({tag, ".ovf"},   32'(bus.out_ovf),   32'd0);
        checkOutput({tag, ".count"}, 32'(bus.out_count), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkIdle("resetInit");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-packet discards the partial sum.
        applyStimulus(16'h0003, 1'b0);
        applyStimulus(16'h0004, 1'b0);
        checkOutput("midPkt.sum", 32'(bus.out_sum), 32'h7);
        rst_n = 1'b0;
        #1;
        checkIdle("midPktReset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle("afterReset");
        applyStimulus(16'h0007, 1'b1);
        checkResult("pkt7", 16'h0007, 1'b0, 1'b0, 8'd1);
        drainResult("pkt7");

        // Three-beat packet; out_valid must still be low on the cycle the
        // last beat is presented and high one cycle later.
        applyStimulus(16'h0003, 1'b0);
        applyStimulus(16'h0004, 1'b0);
        checkOutput("latency.before", 32'(bus.out_valid), 32'd0);
        applyStimulus(16'h0005, 1'b1);
        checkResult("pktC", 16'h000C, 1'b0, 1'b0, 8'd3);
        drainResult("pktC");

        // Unsigned carry-out without signed overflow.
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'h0002, 1'b1);
        checkResult("carry", 16'h0001, 1'b1, 1'b0, 8'd2);
        drainResult("carry");

        // Signed overflow without carry-out; result is then held under
        // backpressure while a beat is offered and must not be consumed.
        applyStimulus(16'h7FFF, 1'b0);
        applyStimulus(16'h0001, 1'b1);
        checkResult("ovf", 16'h8000, 1'b0, 1'b1, 8'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkResult($sformatf("hold%0d", i), 16'h8000, 1'b0, 1'b1, 8'd2);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        drainResult("hold");
        applyStimulus(16'h0001, 1'b1);
        checkResult("pkt1", 16'h0001, 1'b0, 1'b0, 8'd1);
        drainResult("pkt1");

        // Beat counter saturates while the sum keeps counting.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'h0001, (i == 299));
        end
        checkResult("sat", 16'h012C, 1'b0, 1'b0, 8'd255);
        drainResult("sat");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
